tl_phase_sched: RTL

Two-road traffic-light phase scheduler that drives the lamp outputs for a main road (1) and a farm road (2). It sequences green, yellow and all-red phases from programmable tick durations and latches farm-road sensor requests. It also honours an emergency preempt that can force either road green. It sits in the same traffic-control subsystem as the existing light controller and replaces its fixed counter chain with a parameterised, preemptable scheduler.

---
 rtl/tl_phase_sched.sv | 119 +++++++++++
 1 files changed

// File: rtl/tl_phase_sched.sv
// Two-road traffic-light phase scheduler with farm-road request latch and emergency preempt.
// Latency: all outputs registered, inputs act on the next CK edge; no backpressure (free-running).
module tl_phase_sched #(
    parameter int PRESCALE = 16,
    parameter int CNT_W    = 4,
    parameter int T_GRN1   = 8,
    parameter int T_GRN2   = 5,
    parameter int T_YLW    = 3,
    parameter int T_AR     = 1
) (
    input  logic       CK,
    input  logic       CLR,
    input  logic       TEST,
    input  logic       FM,
    input  logic       PRE,
    input  logic       PRE_SEL,
    output logic       GRN1,
    output logic       YLW1,
    output logic       RED1,
    output logic       GRN2,
    output logic       YLW2,
    output logic       RED2,
    output logic [2:0] PHASE,
    output logic       FM_PEND
);

    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] LD_GRN1 = CNT_W'(T_GRN1 - 1);
    localparam logic [CNT_W-1:0] LD_GRN2 = CNT_W'(T_GRN2 - 1);
    localparam logic [CNT_W-1:0] LD_YLW  = CNT_W'(T_YLW - 1);
    localparam logic [CNT_W-1:0] LD_AR   = CNT_W'(T_AR - 1);
    // lamp vector order: {GRN1, YLW1, RED1, GRN2, YLW2, RED2}
    localparam logic [5:0] LAMP_ALLRED = 6'b001_001;

    typedef enum logic [2:0] {
        PH_G1  = 3'd0,
        PH_Y1  = 3'd1,
        PH_AR1 = 3'd2,
        PH_G2  = 3'd3,
        PH_Y2  = 3'd4,
        PH_AR2 = 3'd5
    } phase_e;

    phase_e           state, state_n;
    logic [CNT_W-1:0] timer, timer_n, timer_dec;
    logic [PS_W-1:0]  pcnt;
    logic             tick, expire, fm_pend_n;
    logic [5:0]       lamp, lamp_n;

    function automatic logic [CNT_W-1:0] load_val(input phase_e p);
        case (p)
            PH_G1:         load_val = LD_GRN1;
            PH_G2:         load_val = LD_GRN2;
            PH_Y1, PH_Y2:  load_val = LD_YLW;
            default:       load_val = LD_AR;
        endcase
    endfunction

    assign tick      = TEST || (pcnt == PS_LAST);
    assign expire    = tick && (timer == '0);
    assign timer_dec = (tick && timer != '0) ? timer - CNT_W'(1) : timer;

    always_comb begin
        state_n = state;
        timer_n = timer_dec;
        case (state)
            PH_G1: begin
                if (PRE && PRE_SEL)            state_n = PH_Y1;
                else if (PRE)                  timer_n = timer;
                else if (expire && FM_PEND)    state_n = PH_Y1;
            end
            PH_G2: begin
                if (PRE && !PRE_SEL)           state_n = PH_Y2;
                else if (PRE)                  timer_n = timer;
                else if (expire)               state_n = PH_Y2;
            end
            PH_Y1:  if (expire) state_n = PH_AR1;
            PH_Y2:  if (expire) state_n = PH_AR2;
            // all-red exits honour a preempt selection, even back to the same road
            PH_AR1: if (expire) state_n = (PRE && !PRE_SEL) ? PH_G1 : PH_G2;
            PH_AR2: if (expire) state_n = (PRE && PRE_SEL) ? PH_G2 : PH_G1;
            default: state_n = PH_AR2;
        endcase
        if (state_n != state) timer_n = load_val(state_n);
    end

    always_comb begin
        fm_pend_n = FM_PEND | FM;
        if (state_n == PH_G2 && state != PH_G2) fm_pend_n = 1'b0;
        case (state_n)
            PH_G1:   lamp_n = 6'b100_001;
            PH_Y1:   lamp_n = 6'b010_001;
            PH_G2:   lamp_n = 6'b001_100;
            PH_Y2:   lamp_n = 6'b001_010;
            default: lamp_n = LAMP_ALLRED;
        endcase
    end

    always_ff @(posedge CK) begin
        if (CLR) begin
            state   <= PH_AR2;
            timer   <= LD_AR;
            pcnt    <= '0;
            FM_PEND <= 1'b0;
            lamp    <= LAMP_ALLRED;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            pcnt    <= (TEST || pcnt == PS_LAST) ? '0 : pcnt + PS_W'(1);
            FM_PEND <= fm_pend_n;
            lamp    <= lamp_n;
        end
    end

    assign PHASE = state;
    assign {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = lamp;

endmodule
